// File: rtl/reg_op_sequencer_if.sv
// Command channel into the register op sequencer.
// Valid/ready handshake carrying opcode, load data and shift count.
interface reg_op_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/reg_op_sequencer.sv
// Sequences LOAD/INVERT/SHIFT commands into a 4-bit operate-and-load
// register, feeding reg_q back for multi-cycle shifts.
module reg_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    reg_op_sequencer_if.slave  cmd,
    input  logic [WIDTH-1:0]   reg_q,
    output logic [WIDTH-1:0]   reg_i,
    output logic [1:0]         reg_j,
    output logic               reg_load,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_rem;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_load;
    logic [1:0]       r_j;

    logic [CNT_W-1:0] w_rem_new;
    logic [WIDTH-1:0] w_reg_i;

    // Shifts run cmd_count cycles; LOAD and INVERT always take one.
    assign w_rem_new = cmd.cmd_op[1] ? cmd.cmd_count : CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_data  <= '0;
            r_rem   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_load  <= 1'b0;
            r_j     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        r_op    <= cmd.cmd_op;
                        r_data  <= cmd.cmd_data;
                        r_rem   <= w_rem_new;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_rem_new != '0) begin
                            r_state <= S_EXEC;
                            r_load  <= 1'b1;
                            r_j     <= cmd.cmd_op;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_rem == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_load  <= 1'b0;
                        r_j     <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_rem <= r_rem - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_load  <= 1'b0;
                    r_j     <= '0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Only reg_i sees reg_q combinationally, and only while loading.
    always_comb begin
        w_reg_i = '0;
        if (r_load) begin
            w_reg_i = (r_op == OP_LOAD) ? r_data : reg_q;
        end
    end

    assign reg_i         = w_reg_i;
    assign reg_j         = r_j;
    assign reg_load      = r_load;
    assign busy          = r_busy;
    assign done          = r_done;
    assign cmd.cmd_ready = r_ready;
endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer: vector table, random commands vs a
// shift-arithmetic model, plus held-command and mid-command reset cases.
module tb_reg_op_sequencer;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reg_op_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

    logic [3:0] reg_q;
    logic [3:0] reg_i;
    logic [1:0] reg_j;
    logic       reg_load;
    logic       busy;
    logic       done;

    reg_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd      (cmd_if),
        .reg_q    (reg_q),
        .reg_i    (reg_i),
        .reg_j    (reg_j),
        .reg_load (reg_load),
        .busy     (busy),
        .done     (done)
    );

    // Downstream operate-and-load register (not cleared by reset).
    logic [3:0] q_reg = 4'h0;
    assign reg_q = q_reg;

    function automatic logic [3:0] ds_op(logic [1:0] j, logic [3:0] i);
        case (j)
            2'b00:   return i;
            2'b01:   return ~i;
            2'b10:   return {1'b0, i[3:1]};
            default: return {i[2:0], 1'b0};
        endcase
    endfunction

    always @(posedge clk) if (reg_load) q_reg <= ds_op(reg_j, reg_i);

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] m_q = 4'h0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] shl(logic [3:0] q, int k);
        int t;
        t = int'(q) << k;
        return 4'(t & 15);
    endfunction

    function automatic logic [3:0] model_result(logic [1:0] op, logic [3:0] d,
                                                int cnt, logic [3:0] q);
        case (op)
            2'b00:   return d;
            2'b01:   return ~q;
            2'b10:   return 4'(int'(q) >> cnt);
            default: return shl(q, cnt);
        endcase
    endfunction

    function automatic logic [3:0] exp_i(logic [1:0] op, logic [3:0] d,
                                         logic [3:0] q, int k);
        case (op)
            2'b00:   return d;
            2'b01:   return q;
            2'b10:   return 4'(int'(q) >> k);
            default: return shl(q, k);
        endcase
    endfunction

    // Call at a negedge; returns at a negedge with the DUT idle again.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] d,
                           input int cnt, input logic [3:0] exp_q,
                           input string tag);
        int n;
        int loads;
        int dones;
        int done_at;
        int bad;
        n = op[1] ? cnt : 1;
        loads = 0;
        dones = 0;
        done_at = -1;
        bad = 0;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = d;
        cmd_if.cmd_count = 3'(cnt);
        cmd_if.cmd_valid = 1'b1;
        check({tag, " ready_before"}, int'(cmd_if.cmd_ready), 1);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            if (reg_load) begin
                if (reg_j !== op) bad++;
                if (reg_i !== exp_i(op, d, m_q, loads)) bad++;
                loads++;
            end
            if (done) begin
                dones++;
                done_at = k;
            end
            if (k == n + 1) check({tag, " q_at_done"}, int'(reg_q), int'(exp_q));
            if (k == n + 2) check({tag, " idle_after"},
                                  int'({cmd_if.cmd_ready, busy}), 2);
        end
        check({tag, " load_cycles"}, loads, n);
        check({tag, " done_pulses"}, dones, 1);
        check({tag, " done_cycle"}, done_at, n + 1);
        check({tag, " j_i_per_load"}, bad, 0);
        m_q = exp_q;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] d;
        int         cnt;
        logic [3:0] exp_q;
    } vec_t;

    vec_t vt[13];

    initial begin
        vt[0]  = '{2'b00, 4'b1011, 0, 4'b1011};
        vt[1]  = '{2'b00, 4'b0110, 0, 4'b0110};
        vt[2]  = '{2'b01, 4'b0000, 0, 4'b1001};
        vt[3]  = '{2'b00, 4'b1011, 0, 4'b1011};
        vt[4]  = '{2'b10, 4'b0000, 2, 4'b0010};
        vt[5]  = '{2'b00, 4'b1111, 0, 4'b1111};
        vt[6]  = '{2'b11, 4'b0000, 5, 4'b0000};
        vt[7]  = '{2'b11, 4'b0000, 0, 4'b0000};
        vt[8]  = '{2'b00, 4'b1000, 0, 4'b1000};
        vt[9]  = '{2'b10, 4'b0000, 3, 4'b0001};
        vt[10] = '{2'b11, 4'b1111, 1, 4'b0010};
        vt[11] = '{2'b01, 4'b0000, 0, 4'b1101};
        vt[12] = '{2'b10, 4'b0000, 7, 4'b0000};

        // Reset with a command offered: nothing may be accepted.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_data  = 4'hF;
        cmd_if.cmd_count = 3'd0;
        repeat (3) @(negedge clk);
        check("rst ready", int'(cmd_if.cmd_ready), 1);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst load", int'(reg_load), 0);
        check("rst j_i", int'({reg_j, reg_i}), 0);
        cmd_if.cmd_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 13; v++) begin
            run_cmd(vt[v].op, vt[v].d, vt[v].cnt, vt[v].exp_q,
                    $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 40; r++) begin
            logic [1:0] op;
            logic [3:0] d;
            int cnt;
            op  = 2'($urandom_range(0, 3));
            d   = 4'($urandom);
            cnt = int'($urandom_range(0, 7));
            run_cmd(op, d, cnt, model_result(op, d, cnt, m_q),
                    $sformatf("rnd%0d", r));
        end

        // Second command held while busy: taken only once idle again.
        run_cmd(2'b00, 4'b1011, 0, 4'b1011, "hold_pre");
        begin
            int loads;
            int bad;
            loads = 0;
            bad = 0;
            cmd_if.cmd_op    = 2'b10;
            cmd_if.cmd_count = 3'd3;
            cmd_if.cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            cmd_if.cmd_op   = 2'b00;
            cmd_if.cmd_data = 4'b0101;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (reg_load) begin
                    loads++;
                    if (reg_j !== 2'b10) bad++;
                end
                if (k <= 4 && cmd_if.cmd_ready) bad++;
                if (k == 4) check("hold q_first", int'(reg_q), 1);
                if (k == 5) check("hold ready_back", int'(cmd_if.cmd_ready), 1);
            end
            check("hold first_loads", loads, 3);
            check("hold while_busy", bad, 0);
            @(posedge clk);
            #1 cmd_if.cmd_valid = 1'b0;
            @(negedge clk);
            check("hold second_load", int'({reg_load, reg_j, reg_i}),
                  int'({1'b1, 2'b00, 4'b0101}));
            @(negedge clk);
            check("hold second_done", int'({done, reg_q}),
                  int'({1'b1, 4'b0101}));
            @(negedge clk);
            m_q = 4'b0101;
        end

        // Reset after the second of four right shifts.
        run_cmd(2'b00, 4'b1000, 0, 4'b1000, "abort_pre");
        cmd_if.cmd_op    = 2'b10;
        cmd_if.cmd_count = 3'd4;
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort load", int'(reg_load), 0);
        check("abort busy_done", int'({busy, done}), 0);
        check("abort ready", int'(cmd_if.cmd_ready), 1);
        check("abort j_i", int'({reg_j, reg_i}), 0);
        check("abort q", int'(reg_q), 2);
        reset = 1'b1;
        @(negedge clk);
        check("abort after", int'({done, busy, reg_load, reg_q}), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
